// File: rtl/hub_pkg.sv
// Shared types and helpers for shared_resource_hub.
//  hub_tag_t   : {epoch, channel} request tag (layout for the default 4-channel build)
//  hub_grant_t : result of the round-robin search {found, channel}
//  tag_w()     : tag width for a given channel count
//  rr_next()   : first requesting channel at or above the rr pointer, wrapping
package hub_pkg;

  localparam int HUB_MAX_CH   = 16;
  localparam int HUB_MAX_CH_W = 4;
  localparam int HUB_TAG_CH_W = 2;

  typedef struct packed {
    logic                    epoch;
    logic [HUB_TAG_CH_W-1:0] ch;
  } hub_tag_t;

  typedef struct packed {
    logic                    found;
    logic [HUB_MAX_CH_W-1:0] ch;
  } hub_grant_t;

  function automatic int tag_w(input int n_ch);
    return $clog2(n_ch) + 1;
  endfunction

  // Requests are padded to HUB_MAX_CH; only the low n_ch entries take part.
  function automatic hub_grant_t rr_next(input logic [HUB_MAX_CH-1:0]   req,
                                         input logic [HUB_MAX_CH_W-1:0] ptr,
                                         input int                      n_ch);
    hub_grant_t g;
    int         idx;
    g.found = 1'b0;
    g.ch    = {HUB_MAX_CH_W{1'b0}};
    for (int k = 0; k < HUB_MAX_CH; k++) begin
      idx = (int'(ptr) + k) % n_ch;
      if ((k < n_ch) && !g.found && req[idx[HUB_MAX_CH_W-1:0]]) begin
        g.found = 1'b1;
        g.ch    = idx[HUB_MAX_CH_W-1:0];
      end else begin
        g.found = g.found;
      end
    end
    return g;
  endfunction

endpackage

// File: rtl/hub_chan_fifo.sv
// Per-channel synchronous FIFO with first-word fall-through read data.
//  clk, reset(async active-low)
//  wr/wdata : write strobe and payload (ignored while full or flushing)
//  rd/rdata : pop strobe and head-of-queue payload
//  flush    : empties the FIFO; wins over a same-cycle write or pop
//  full/empty : decoded from registered pointers only
module hub_chan_fifo #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              rd,
  output logic [DATA_W-1:0] rdata,
  input  logic              flush,
  output logic              full,
  output logic              empty
);

  localparam int AW = $clog2(DEPTH);

  // Pointers carry one extra MSB so full and empty differ only by the wrap bit.
  logic [AW:0]       wr_ptr_r;
  logic [AW:0]       rd_ptr_r;
  logic [DATA_W-1:0] mem_r [DEPTH];
  logic              wr_en_s;
  logic              rd_en_s;

  assign wr_en_s = wr & ~full & ~flush;
  assign rd_en_s = rd & ~empty & ~flush;
  assign empty   = (wr_ptr_r == rd_ptr_r);
  assign full    = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                   (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign rdata   = mem_r[rd_ptr_r[AW-1:0]];

  // Pointer update; flush returns both pointers to zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else if (flush) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else begin
      if (wr_en_s) wr_ptr_r <= wr_ptr_r + (AW+1)'(1);
      if (rd_en_s) rd_ptr_r <= rd_ptr_r + (AW+1)'(1);
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (wr_en_s) mem_r[wr_ptr_r[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/shared_resource_hub.sv
// N-channel front end for one shared execution resource.
// Per-channel FIFOs feed a round-robin arbiter and a registered issue stage.
// Requests carry {epoch, channel}; responses are routed back by tag and dropped
// when their epoch no longer matches the channel (stale after a flush).
//  clk, reset(async active-low)
//  ch_in_data/ch_in_valid/ch_stall : per-channel producer interface
//  ch_flush                        : per-channel flush pulse
//  res_req_*                       : request to the shared resource (valid/ready)
//  res_rsp_*                       : response from the resource (no backpressure)
//  ch_out_data/ch_out_valid        : registered per-channel result
//  ch_starve                       : starvation flags
// Optional build macro: HUB_STARVE_MON_EN enables the per-channel wait counters.
module shared_resource_hub
  import hub_pkg::*;
#(
  parameter  int N_CH       = 4,
  parameter  int DATA_W     = 32,
  parameter  int FIFO_DEPTH = 4,
  parameter  int STARVE_LIM = 16,
  localparam int CH_W       = $clog2(N_CH),
  localparam int TAG_W      = tag_w(N_CH)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_CH*DATA_W-1:0] ch_in_data,
  input  logic [N_CH-1:0]        ch_in_valid,
  input  logic [N_CH-1:0]        ch_flush,
  output logic [N_CH-1:0]        ch_stall,
  output logic                   res_req_valid,
  output logic [DATA_W-1:0]      res_req_data,
  output logic [TAG_W-1:0]       res_req_tag,
  input  logic                   res_req_ready,
  input  logic                   res_rsp_valid,
  input  logic [DATA_W-1:0]      res_rsp_data,
  input  logic [TAG_W-1:0]       res_rsp_tag,
  output logic [N_CH*DATA_W-1:0] ch_out_data,
  output logic [N_CH-1:0]        ch_out_valid,
  output logic [N_CH-1:0]        ch_starve
);

  logic [N_CH-1:0]        empty_s;
  logic [N_CH-1:0]        full_s;
  logic [N_CH-1:0]        rd_s;
  logic [DATA_W-1:0]      rdata_s [N_CH];
  logic [N_CH-1:0]        epoch_r;
  logic [CH_W-1:0]        rr_ptr_r;
  logic                   req_valid_r;
  logic [DATA_W-1:0]      req_data_r;
  logic [TAG_W-1:0]       req_tag_r;
  logic [HUB_MAX_CH-1:0]  req_s;
  hub_grant_t             grant_s;
  logic [CH_W-1:0]        gnt_ch_s;
  logic                   load_s;
  logic [CH_W-1:0]        rsp_ch_s;
  logic [N_CH-1:0]        out_sel_s;
  logic [N_CH-1:0]        out_valid_r;
  logic [N_CH*DATA_W-1:0] out_data_r;

  for (genvar i = 0; i < N_CH; i++) begin : g_fifo
    hub_chan_fifo #(.DEPTH(FIFO_DEPTH), .DATA_W(DATA_W)) u_fifo (
      .clk   (clk),
      .reset (reset),
      .wr    (ch_in_valid[i]),
      .wdata (ch_in_data[i*DATA_W +: DATA_W]),
      .rd    (rd_s[i]),
      .rdata (rdata_s[i]),
      .flush (ch_flush[i]),
      .full  (full_s[i]),
      .empty (empty_s[i])
    );
  end

  assign ch_stall = full_s;
  assign load_s   = ~req_valid_r | res_req_ready;
  assign grant_s  = rr_next(req_s, HUB_MAX_CH_W'(rr_ptr_r), N_CH);
  assign gnt_ch_s = CH_W'(grant_s.ch);

  // Arbiter request vector; a channel being flushed this cycle is not eligible.
  always_comb begin
    req_s            = '0;
    req_s[N_CH-1:0]  = ~empty_s & ~ch_flush;
  end

  // Pop the granted FIFO whenever the issue register takes a new entry.
  always_comb begin
    rd_s = '0;
    if (load_s && grant_s.found) begin
      rd_s[gnt_ch_s] = 1'b1;
    end else begin
      rd_s = '0;
    end
  end

  // Issue register and rr pointer; outputs hold while valid and not ready.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      req_valid_r <= 1'b0;
      req_data_r  <= '0;
      req_tag_r   <= '0;
      rr_ptr_r    <= '0;
    end else if (load_s) begin
      if (grant_s.found) begin
        req_valid_r <= 1'b1;
        req_data_r  <= rdata_s[gnt_ch_s];
        req_tag_r   <= {epoch_r[gnt_ch_s], gnt_ch_s};
        rr_ptr_r    <= (gnt_ch_s == CH_W'(N_CH - 1)) ? '0 : gnt_ch_s + CH_W'(1);
      end else begin
        req_valid_r <= 1'b0;
      end
    end
  end

  // Epoch bits flip on flush so in-flight responses become stale.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) epoch_r <= '0;
    else        epoch_r <= epoch_r ^ ch_flush;
  end

  assign rsp_ch_s = res_rsp_tag[CH_W-1:0];

  // Response demux; compares against the pre-flush epoch register.
  always_comb begin
    out_sel_s = '0;
    if (res_rsp_valid && (int'(rsp_ch_s) < N_CH) &&
        (res_rsp_tag[CH_W] == epoch_r[rsp_ch_s])) begin
      out_sel_s[rsp_ch_s] = 1'b1;
    end else begin
      out_sel_s = '0;
    end
  end

  // Registered result outputs; data of idle channels keeps its last value.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid_r <= '0;
      out_data_r  <= '0;
    end else begin
      out_valid_r <= out_sel_s;
      for (int i = 0; i < N_CH; i++) begin
        if (out_sel_s[i]) out_data_r[i*DATA_W +: DATA_W] <= res_rsp_data;
      end
    end
  end

  assign res_req_valid = req_valid_r;
  assign res_req_data  = req_data_r;
  assign res_req_tag   = req_tag_r;
  assign ch_out_valid  = out_valid_r;
  assign ch_out_data   = out_data_r;

`ifdef HUB_STARVE_MON_EN
  localparam int SW = $clog2(STARVE_LIM + 1);

  logic [SW-1:0]   wait_cnt_r [N_CH];
  logic [N_CH-1:0] starve_r;

  // Wait counters saturate at STARVE_LIM; the flag is registered alongside.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N_CH; i++) wait_cnt_r[i] <= '0;
      starve_r <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (ch_flush[i] || rd_s[i]) begin
          wait_cnt_r[i] <= '0;
          starve_r[i]   <= 1'b0;
        end else if (!empty_s[i] && (wait_cnt_r[i] != SW'(STARVE_LIM))) begin
          wait_cnt_r[i] <= wait_cnt_r[i] + SW'(1);
          starve_r[i]   <= (wait_cnt_r[i] == SW'(STARVE_LIM - 1));
        end
      end
    end
  end

  assign ch_starve = starve_r;
`else
  logic [31:0] unused_starve_lim_s;
  assign unused_starve_lim_s = 32'(STARVE_LIM);
  assign ch_starve           = '0;
`endif

endmodule

// File: tb/tb_shared_resource_hub.sv
// Scoreboard bench for shared_resource_hub (default parameters).
module tb_shared_resource_hub;
  import hub_pkg::*;

  logic         clk = 1'b0;
  logic         reset;
  logic [127:0] ch_in_data;
  logic [3:0]   ch_in_valid;
  logic [3:0]   ch_flush;
  logic [3:0]   ch_stall;
  logic         res_req_valid;
  logic [31:0]  res_req_data;
  logic [2:0]   res_req_tag;
  logic         res_req_ready;
  logic         res_rsp_valid;
  logic [31:0]  res_rsp_data;
  logic [2:0]   res_rsp_tag;
  logic [127:0] ch_out_data;
  logic [3:0]   ch_out_valid;
  logic [3:0]   ch_starve;

  int checks = 0;
  int errors = 0;
  logic [63:0] req_q[$];
  logic [63:0] out_q[$];

`ifdef HUB_STARVE_MON_EN
  localparam bit MON_EN = 1'b1;
`else
  localparam bit MON_EN = 1'b0;
`endif

  shared_resource_hub dut (
    .clk(clk), .reset(reset), .ch_in_data(ch_in_data), .ch_in_valid(ch_in_valid),
    .ch_flush(ch_flush), .ch_stall(ch_stall), .res_req_valid(res_req_valid),
    .res_req_data(res_req_data), .res_req_tag(res_req_tag), .res_req_ready(res_req_ready),
    .res_rsp_valid(res_rsp_valid), .res_rsp_data(res_rsp_data), .res_rsp_tag(res_rsp_tag),
    .ch_out_data(ch_out_data), .ch_out_valid(ch_out_valid), .ch_starve(ch_starve)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [2:0] tg(input logic e, input logic [1:0] c);
    hub_tag_t t;
    t.epoch = e;
    t.ch    = c;
    return t;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every request handshake and every result pulse is scored.
  always @(negedge clk) begin
    if (reset) begin
      if (res_req_valid && res_req_ready) begin
        if (req_q.size() == 0) chk("req_unexpected", 64'(req_q.size()), 64'd1);
        else chk("req", 64'({res_req_tag, res_req_data}), req_q.pop_front());
      end
      for (int c = 0; c < 4; c++) begin
        if (ch_out_valid[c]) begin
          if (out_q.size() == 0) chk("out_unexpected", 64'(out_q.size()), 64'd1);
          else chk("out", 64'({c[3:0], ch_out_data[c*32 +: 32]}), out_q.pop_front());
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b0; ch_in_data = '0; ch_in_valid = 4'd0; ch_flush = 4'd0;
    res_req_ready = 1'b0; res_rsp_valid = 1'b0; res_rsp_data = 32'd0; res_rsp_tag = 3'd0;
    step(); step();
    chk("rst_req_valid", 64'(res_req_valid), 64'd0);
    chk("rst_req_data", 64'(res_req_data), 64'd0);
    chk("rst_out", 64'({ch_out_valid, ch_stall, ch_starve}), 64'd0);
    reset = 1'b1;
    step();

    // Fairness: two entries per channel, grant order 0,1,2,3,0,1,2,3 without gaps.
    for (int k = 0; k < 2; k++) begin
      for (int c = 0; c < 4; c++) ch_in_data[c*32 +: 32] = 32'hF000_0000 + 32'(c*16 + k);
      ch_in_valid = 4'hF;
      step();
    end
    ch_in_valid = 4'd0;
    for (int k = 0; k < 2; k++)
      for (int c = 0; c < 4; c++)
        req_q.push_back(64'({tg(1'b0, c[1:0]), 32'hF000_0000 + 32'(c*16 + k)}));
    res_req_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("fair_no_gap", 64'(res_req_valid), 64'd1);
      step();
    end
    chk("fair_drained", 64'(res_req_valid), 64'd0);

    // Single request: latency, tag and routed result.
    ch_in_data[2*32 +: 32] = 32'hA5A5_0001;
    ch_in_valid = 4'b0100;
    req_q.push_back(64'({tg(1'b0, 2'd2), 32'hA5A5_0001}));
    step();
    ch_in_valid = 4'd0;
    chk("single_not_yet", 64'(res_req_valid), 64'd0);
    step();
    chk("single_valid", 64'(res_req_valid), 64'd1);
    chk("single_tag", 64'(res_req_tag), 64'd2);
    res_rsp_valid = 1'b1; res_rsp_tag = tg(1'b0, 2'd2); res_rsp_data = 32'hA5A5_0001;
    out_q.push_back(64'({4'd2, 32'hA5A5_0001}));
    step();
    res_rsp_valid = 1'b0;
    chk("single_out_valid", 64'(ch_out_valid), 64'h4);
    step();
    chk("single_out_pulse", 64'(ch_out_valid), 64'h0);

    // Backpressure: stall after five accepts, sixth write dropped, outputs stable.
    res_req_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      ch_in_data[31:0] = 32'hB000_0000 + 32'(k);
      ch_in_valid = 4'b0001;
      if (k < 5) req_q.push_back(64'({tg(1'b0, 2'd0), 32'hB000_0000 + 32'(k)}));
      step();
      chk("bp_stall", 64'(ch_stall[0]), 64'(k >= 4));
      if (k >= 1) chk("bp_stable", 64'({res_req_valid, res_req_tag, res_req_data}),
                      64'({1'b1, 3'd0, 32'hB000_0000}));
    end
    ch_in_valid = 4'd0;
    res_req_ready = 1'b1;
    for (int i = 0; i < 6; i++) step();
    chk("bp_unstall", 64'(ch_stall[0]), 64'd0);
    chk("bp_drained", 64'(res_req_valid), 64'd0);
    res_req_ready = 1'b0;

    // Flush: issued request survives, queued entry is discarded, epoch toggles.
    ch_in_data[63:32] = 32'hC100_0001;
    ch_in_valid = 4'b0010;
    req_q.push_back(64'({tg(1'b0, 2'd1), 32'hC100_0001}));
    step();
    ch_in_data[63:32] = 32'hC100_0002;
    step();
    ch_in_valid = 4'd0;
    ch_flush = 4'b0010;
    step();
    ch_flush = 4'd0;
    chk("flush_held_req", 64'({res_req_valid, res_req_tag}), 64'({1'b1, 3'd1}));
    res_req_ready = 1'b1;
    step();
    res_req_ready = 1'b0;
    chk("flush_fifo_empty", 64'(res_req_valid), 64'd0);
    res_rsp_valid = 1'b1; res_rsp_tag = tg(1'b0, 2'd1); res_rsp_data = 32'hDEAD_0001;
    step();
    chk("flush_stale_drop", 64'(ch_out_valid), 64'd0);
    res_rsp_tag = tg(1'b1, 2'd1); res_rsp_data = 32'h1111_2222;
    out_q.push_back(64'({4'd1, 32'h1111_2222}));
    step();
    res_rsp_valid = 1'b0;
    chk("flush_new_epoch", 64'(ch_out_valid), 64'h2);

    // Same-cycle flush and write on ch3: write is lost, epoch3 becomes 1.
    res_req_ready = 1'b1;
    ch_in_data[127:96] = 32'hD300_0000;
    ch_in_valid = 4'b1000; ch_flush = 4'b1000;
    step();
    ch_in_valid = 4'd0; ch_flush = 4'd0;
    step();
    chk("coll_fifo3_empty", 64'({res_req_valid, ch_stall[3]}), 64'd0);
    res_rsp_valid = 1'b1; res_rsp_tag = tg(1'b1, 2'd3); res_rsp_data = 32'h3333_0003;
    out_q.push_back(64'({4'd3, 32'h3333_0003}));
    step();
    res_rsp_valid = 1'b0;

    // Reset mid-traffic: every output drops at once.
    res_req_ready = 1'b0;
    for (int c = 0; c < 4; c++) ch_in_data[c*32 +: 32] = 32'hE000_0000 + 32'(c);
    ch_in_valid = 4'hF;
    step();
    res_rsp_valid = 1'b1; res_rsp_tag = tg(1'b0, 2'd0); res_rsp_data = 32'h0000_BEEF;
    step();
    reset = 1'b0;
    #1;
    chk("mid_rst_req", 64'({res_req_valid, res_req_tag, res_req_data}), 64'd0);
    chk("mid_rst_out", 64'({ch_out_valid, ch_stall, ch_starve}), 64'd0);
    chk("mid_rst_data", ch_out_data[63:0] | ch_out_data[127:64], 64'd0);
    ch_in_valid = 4'd0; res_rsp_valid = 1'b0;
    step(); step();
    reset = 1'b1;
    step();
    // Epoch3 is back to 0 after reset.
    res_rsp_valid = 1'b1; res_rsp_tag = tg(1'b0, 2'd3); res_rsp_data = 32'h3333_1111;
    out_q.push_back(64'({4'd3, 32'h3333_1111}));
    step();
    res_rsp_valid = 1'b0;
    chk("rst_epoch3", 64'(ch_out_valid), 64'h8);

    // Starvation: ch0 entry waits 20 cycles behind a blocked issue register.
    ch_in_data[31:0] = 32'h5000_0000;
    ch_in_valid = 4'b0001;
    req_q.push_back(64'({tg(1'b0, 2'd0), 32'h5000_0000}));
    step();
    ch_in_data[31:0] = 32'h5000_0001;
    req_q.push_back(64'({tg(1'b0, 2'd0), 32'h5000_0001}));
    step();
    ch_in_valid = 4'd0;
    for (int w = 1; w <= 20; w++) begin
      step();
      chk("starve_wait", 64'(ch_starve[0]), 64'(MON_EN && (w >= 16)));
    end
    res_req_ready = 1'b1;
    step();
    chk("starve_clear", 64'(ch_starve[0]), 64'd0);
    step();
    res_req_ready = 1'b0;
    step();

    chk("req_q_empty", 64'(req_q.size()), 64'd0);
    chk("out_q_empty", 64'(out_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
